icache_fetch_responder: RTL and testbench



---
 rtl/icache_fetch_responder_pkg.sv | 45 ++++
 rtl/icache_fetch_responder_if.sv | 39 +++
 rtl/icache_fetch_responder_line_array.sv | 54 +++++
 rtl/icache_fetch_responder.sv | 156 +++++++++++++++
 tb/tb_icache_fetch_responder.sv | 345 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/icache_fetch_responder_pkg.sv
// Shared types for the direct-mapped fetch I-cache: address split, line storage and FSM states.
// RSD_ICACHE_FLUSH_EN adds the FLUSH state used by the invalidate-all path.
package ICacheTypes;

    localparam int FETCH_WIDTH = 2;
    localparam int INSN_WIDTH  = 32;
    localparam int ADDR_WIDTH  = 32;
    localparam int LINE_INSNS  = 4;
    localparam int SETS        = 64;

    localparam int OFF_W   = $clog2(LINE_INSNS);
    localparam int IDX_W   = $clog2(SETS);
    localparam int WADDR_W = ADDR_WIDTH - 2;
    localparam int TAG_W   = WADDR_W - OFF_W - IDX_W;

    typedef logic [OFF_W-1:0]      offset_t;
    typedef logic [IDX_W-1:0]      index_t;
    typedef logic [TAG_W-1:0]      tag_t;
    typedef logic [WADDR_W-1:0]    waddr_t;
    typedef logic [INSN_WIDTH-1:0] insn_t;
    typedef insn_t [LINE_INSNS-1:0] line_t;

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_MISS_REQ = 2'd1,
        S_REFILL   = 2'd2
`ifdef RSD_ICACHE_FLUSH_EN
        , S_FLUSH  = 2'd3
`endif
    } state_e;

    // Field extraction works on the word address (byte bits already dropped).
    function automatic offset_t addr_offset(input waddr_t a);
        return a[OFF_W-1:0];
    endfunction

    function automatic index_t addr_index(input waddr_t a);
        return a[OFF_W +: IDX_W];
    endfunction

    function automatic tag_t addr_tag(input waddr_t a);
        return a[OFF_W+IDX_W +: TAG_W];
    endfunction

endpackage

// File: rtl/icache_fetch_responder_if.sv
// Fetch-side read port and memory-side refill channels of the I-cache.
// flushReq/flushDone exist only with RSD_ICACHE_FLUSH_EN.
interface icache_fetch_responder_if;
    import ICacheTypes::*;

    logic                              icRE;
    logic [ADDR_WIDTH-1:0]             icReadAddrIn;
    logic [FETCH_WIDTH-1:0]            icReadHit;
    logic [FETCH_WIDTH*INSN_WIDTH-1:0] icReadDataOut;

    // memReq: a transfer happens on a cycle with memReqValid && memReqReady; once raised,
    // memReqValid and memReqAddr stay stable until that cycle. memRsp has no back-pressure.
    logic                              memReqValid;
    logic                              memReqReady;
    logic [ADDR_WIDTH-1:0]             memReqAddr;
    logic                              memRspValid;
    logic [INSN_WIDTH-1:0]             memRspData;
`ifdef RSD_ICACHE_FLUSH_EN
    logic                              flushReq;
    logic                              flushDone;
`endif

    modport slave (
        input  icRE, icReadAddrIn, memReqReady, memRspValid, memRspData,
        output icReadHit, icReadDataOut, memReqValid, memReqAddr
`ifdef RSD_ICACHE_FLUSH_EN
        , input flushReq, output flushDone
`endif
    );

    modport master (
        output icRE, icReadAddrIn, memReqReady, memRspValid, memRspData,
        input  icReadHit, icReadDataOut, memReqValid, memReqAddr
`ifdef RSD_ICACHE_FLUSH_EN
        , output flushReq, input flushDone
`endif
    );

endinterface

// File: rtl/icache_fetch_responder_line_array.sv
// Valid/tag/data storage with a registered one-line read, one write port and a per-set valid clear.
// The clear port is driven only when RSD_ICACHE_FLUSH_EN is defined.
module icache_line_array
    import ICacheTypes::*;
(
    input  logic   clk,
    input  logic   rst,
    input  index_t i_rd_idx,
    output logic   o_rd_valid,
    output tag_t   o_rd_tag,
    output line_t  o_rd_line,
    input  logic   i_we,
    input  index_t i_wr_idx,
    input  tag_t   i_wr_tag,
    input  line_t  i_wr_line,
    input  logic   i_clr,
    input  index_t i_clr_idx
);

    logic [SETS-1:0] r_valid;
    tag_t            r_tag  [SETS];
    line_t           r_data [SETS];
    logic            r_rd_valid;
    tag_t            r_rd_tag;
    line_t           r_rd_line;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_valid    <= '0;
            r_rd_valid <= 1'b0;
            r_rd_tag   <= '0;
            r_rd_line  <= '0;
        end else begin
            if (i_clr) r_valid[i_clr_idx] <= 1'b0;
            if (i_we)  r_valid[i_wr_idx]  <= 1'b1;
            // Read returns pre-write contents when the same set is written this cycle.
            r_rd_valid <= r_valid[i_rd_idx];
            r_rd_tag   <= r_tag[i_rd_idx];
            r_rd_line  <= r_data[i_rd_idx];
        end
    end

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_tag[i_wr_idx]  <= i_wr_tag;
            r_data[i_wr_idx] <= i_wr_line;
        end
    end

    assign o_rd_valid = r_rd_valid;
    assign o_rd_tag   = r_rd_tag;
    assign o_rd_line  = r_rd_line;

endmodule

// File: rtl/icache_fetch_responder.sv
// Direct-mapped fetch I-cache: 1-cycle lookup, head-lane miss triggers a beat-serial line refill.
// RSD_ICACHE_FLUSH_EN enables the invalidate-all flush (one set per cycle).
module icache_fetch_responder
    import ICacheTypes::*;
(
    input  logic                      clk,
    input  logic                      rst,
    icache_fetch_responder_if.slave   bus,
    output state_e                    o_dbg_state
);

    state_e  r_state, w_next_state;
    logic    r_req_valid, r_req_idle;
    waddr_t  r_req_word;
    tag_t    r_miss_tag;
    index_t  r_miss_idx;
    offset_t r_beat_cnt;
    line_t   r_line_buf;

    logic                              w_rd_valid;
    tag_t                              w_rd_tag;
    line_t                             w_rd_line;
    logic                              w_arr_we, w_clr, w_miss, w_serve, w_flush_done;
    index_t                            w_clr_idx;
    line_t                             w_wr_line;
    logic [OFF_W:0]                    w_pos;
    logic [FETCH_WIDTH-1:0]            w_hit_raw;
    logic [FETCH_WIDTH*INSN_WIDTH-1:0] w_data;

    icache_line_array u_array (
        .clk        (clk),
        .rst        (rst),
        .i_rd_idx   (addr_index(waddr_t'(bus.icReadAddrIn[ADDR_WIDTH-1:2]))),
        .o_rd_valid (w_rd_valid),
        .o_rd_tag   (w_rd_tag),
        .o_rd_line  (w_rd_line),
        .i_we       (w_arr_we),
        .i_wr_idx   (r_miss_idx),
        .i_wr_tag   (r_miss_tag),
        .i_wr_line  (w_wr_line),
        .i_clr      (w_clr),
        .i_clr_idx  (w_clr_idx)
    );

    // A lane hits only inside the line; lanes that spill past the end never refill.
    always_comb begin
        w_pos     = '0;
        w_hit_raw = '0;
        w_data    = '0;
        for (int i = 0; i < FETCH_WIDTH; i++) begin
            w_pos = {1'b0, addr_offset(r_req_word)} + (OFF_W+1)'(i);
            w_hit_raw[i] = w_rd_valid && (w_rd_tag == addr_tag(r_req_word)) && !w_pos[OFF_W];
            w_data[i*INSN_WIDTH +: INSN_WIDTH] = w_rd_line[w_pos[OFF_W-1:0]];
        end
    end

    assign w_serve = r_req_valid && r_req_idle && (r_state == S_IDLE);
    assign w_miss  = w_serve && !w_hit_raw[0];

    assign bus.icReadHit     = w_hit_raw & {FETCH_WIDTH{w_serve}};
    assign bus.icReadDataOut = w_data;
    assign bus.memReqValid   = (r_state == S_MISS_REQ);
    assign bus.memReqAddr    = {r_miss_tag, r_miss_idx, {(OFF_W+2){1'b0}}};
    assign o_dbg_state       = r_state;

    always_comb begin
        w_wr_line = r_line_buf;
        w_wr_line[LINE_INSNS-1] = bus.memRspData;
    end

`ifdef RSD_ICACHE_FLUSH_EN
    logic   r_flush_pending;
    index_t r_flush_idx;
    logic   w_flush_take;

    assign w_flush_take  = (r_state == S_IDLE) && (bus.flushReq || r_flush_pending);
    assign w_clr         = (r_state == S_FLUSH);
    assign w_clr_idx     = r_flush_idx;
    assign bus.flushDone = w_flush_done;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_flush_pending <= 1'b0;
            r_flush_idx     <= '0;
        end else begin
            if (w_flush_take)      r_flush_pending <= 1'b0;
            else if (bus.flushReq) r_flush_pending <= 1'b1;
            r_flush_idx <= (r_state == S_FLUSH) ? r_flush_idx + 1'b1 : '0;
        end
    end
`else
    assign w_clr     = 1'b0;
    assign w_clr_idx = '0;
`endif

    always_comb begin
        w_next_state = r_state;
        w_arr_we     = 1'b0;
        w_flush_done = 1'b0;
        case (r_state)
            S_IDLE: begin
`ifdef RSD_ICACHE_FLUSH_EN
                if (w_flush_take)  w_next_state = S_FLUSH;
                else if (w_miss)   w_next_state = S_MISS_REQ;
`else
                if (w_miss)        w_next_state = S_MISS_REQ;
`endif
            end
            S_MISS_REQ: if (bus.memReqReady) w_next_state = S_REFILL;
            S_REFILL: begin
                if (bus.memRspValid && (r_beat_cnt == offset_t'(LINE_INSNS-1))) begin
                    w_arr_we     = 1'b1;
                    w_next_state = S_IDLE;
                end
            end
`ifdef RSD_ICACHE_FLUSH_EN
            S_FLUSH: begin
                if (r_flush_idx == index_t'(SETS-1)) begin
                    w_flush_done = 1'b1;
                    w_next_state = S_IDLE;
                end
            end
`endif
            default: w_next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state     <= S_IDLE;
            r_req_valid <= 1'b0;
            r_req_idle  <= 1'b0;
            r_req_word  <= '0;
            r_miss_tag  <= '0;
            r_miss_idx  <= '0;
            r_beat_cnt  <= '0;
            r_line_buf  <= '0;
        end else begin
            r_state     <= w_next_state;
            r_req_valid <= bus.icRE;
            r_req_idle  <= (r_state == S_IDLE);
            r_req_word  <= bus.icReadAddrIn[ADDR_WIDTH-1:2];
            if (w_miss) begin
                r_miss_tag <= addr_tag(r_req_word);
                r_miss_idx <= addr_index(r_req_word);
            end
            if ((r_state == S_MISS_REQ) && bus.memReqReady) begin
                r_beat_cnt <= '0;
            end else if ((r_state == S_REFILL) && bus.memRspValid) begin
                r_line_buf[r_beat_cnt] <= bus.memRspData;
                r_beat_cnt             <= r_beat_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_icache_fetch_responder.sv
// Bench for icache_fetch_responder: bench-side cache model feeds a read scoreboard; refill/reset
// scenarios check the memory channel inline. Flush scenario built with RSD_ICACHE_FLUSH_EN.
module tb_icache_fetch_responder;
  import ICacheTypes::*;

  localparam int RW = FETCH_WIDTH + FETCH_WIDTH*INSN_WIDTH;
  localparam int LINE_BYTES = LINE_INSNS * 4;

  logic   clk;
  logic   rst;
  state_e dbg_state;

  icache_fetch_responder_if bus();

  icache_fetch_responder dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .o_dbg_state (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  logic [RW-1:0] exp_q[$];
  logic [RW-1:0] mon_exp;
  logic [RW-1:0] mon_mask;
  logic          mon_active = 1'b0;
  logic          mon_req    = 1'b0;

  logic                  m_valid [SETS];
  logic [TAG_W-1:0]      m_tag   [SETS];
  logic [INSN_WIDTH-1:0] m_line  [SETS][LINE_INSNS];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic model_clear();
    for (int s = 0; s < SETS; s++) m_valid[s] = 1'b0;
  endtask

  // driver: one read request; expectation comes from the model unless the cache is busy
  task automatic issue(input logic [ADDR_WIDTH-1:0] addr, input bit busy);
    logic [FETCH_WIDTH-1:0]            eh;
    logic [FETCH_WIDTH*INSN_WIDTH-1:0] ed;
    int off, idx;
    logic [TAG_W-1:0] tg;
    off = int'((addr >> 2) % LINE_INSNS);
    idx = int'((addr >> (2 + OFF_W)) % SETS);
    tg  = TAG_W'(addr >> (2 + OFF_W + IDX_W));
    eh = '0;
    ed = '0;
    for (int i = 0; i < FETCH_WIDTH; i++) begin
      if (!busy && m_valid[idx] && (m_tag[idx] == tg) && (off + i < LINE_INSNS)) begin
        eh[i] = 1'b1;
        ed[i*INSN_WIDTH +: INSN_WIDTH] = m_line[idx][off + i];
      end
    end
    exp_q.push_back({eh, ed});
    bus.icRE = 1'b1;
    bus.icReadAddrIn = addr;
    step();
    bus.icRE = 1'b0;
  endtask

  // scoreboard: compare each response the cycle after its request; idle cycles must show no hit
  always @(posedge clk) mon_req <= bus.icRE;

  always @(negedge clk) begin
    if (mon_active) begin
      n_checks++;
      if (mon_req) begin
        if (exp_q.size() == 0) begin
          $display("FAIL read_resp: response with empty expected queue at %0t", $time);
        end else begin
          mon_exp  = exp_q.pop_front();
          mon_mask = '0;
          mon_mask[RW-1 -: FETCH_WIDTH] = '1;
          for (int i = 0; i < FETCH_WIDTH; i++)
            if (mon_exp[FETCH_WIDTH*INSN_WIDTH + i])
              mon_mask[i*INSN_WIDTH +: INSN_WIDTH] = '1;
          if (({bus.icReadHit, bus.icReadDataOut} & mon_mask) !== mon_exp)
            $display("FAIL read_resp @%0t: got hit=%b data=%h, expected hit=%b data=%h", $time,
                     bus.icReadHit, bus.icReadDataOut & mon_mask[FETCH_WIDTH*INSN_WIDTH-1:0],
                     mon_exp[RW-1 -: FETCH_WIDTH], mon_exp[FETCH_WIDTH*INSN_WIDTH-1:0]);
          else n_pass++;
        end
      end else begin
        if (bus.icReadHit !== '0)
          $display("FAIL idle_hit @%0t: got hit=%b, expected 0", $time, bus.icReadHit);
        else n_pass++;
      end
    end
  end

  // read that misses in the model: check memReqValid stays low at N+1 and rises at N+2
  task automatic start_miss(input logic [ADDR_WIDTH-1:0] addr);
    logic [ADDR_WIDTH-1:0] line;
    line = addr & ~ADDR_WIDTH'(LINE_BYTES - 1);
    issue(addr, 1'b0);
    n_checks++;
    if (bus.memReqValid !== 1'b0)
      $display("FAIL miss_early: memReqValid=%b at detect cycle, expected 0", bus.memReqValid);
    else n_pass++;
    step();
    n_checks++;
    if (bus.memReqValid !== 1'b1 || bus.memReqAddr !== line)
      $display("FAIL miss_req: valid=%b addr=%h, expected valid=1 addr=%h",
               bus.memReqValid, bus.memReqAddr, line);
    else n_pass++;
  endtask

  // refill handshake with optional ready stall and gaps between beats
  task automatic refill(input logic [ADDR_WIDTH-1:0] line, input logic [INSN_WIDTH-1:0] base,
                        input int stall, input int gap);
    int idx;
    idx = int'((line >> (2 + OFF_W)) % SETS);
    for (int w = 0; w < stall; w++) begin
      n_checks++;
      if (bus.memReqValid !== 1'b1 || bus.memReqAddr !== line)
        $display("FAIL req_hold: cycle %0d valid=%b addr=%h, expected 1 %h",
                 w, bus.memReqValid, bus.memReqAddr, line);
      else n_pass++;
      issue(line, 1'b1);
    end
    n_checks++;
    if (bus.memReqValid !== 1'b1 || bus.memReqAddr !== line)
      $display("FAIL req_at_handshake: valid=%b addr=%h, expected 1 %h",
               bus.memReqValid, bus.memReqAddr, line);
    else n_pass++;
    bus.memReqReady = 1'b1;
    step();
    bus.memReqReady = 1'b0;
    n_checks++;
    if (dbg_state !== S_REFILL)
      $display("FAIL enter_refill: state=%0d, expected %0d", dbg_state, S_REFILL);
    else n_pass++;
    for (int k = 0; k < LINE_INSNS; k++) begin
      repeat (gap) step();
      bus.memRspValid = 1'b1;
      bus.memRspData  = base + INSN_WIDTH'(k);
      if (k == LINE_INSNS - 1) issue(line, 1'b1);
      else step();
      bus.memRspValid = 1'b0;
    end
    n_checks++;
    if (dbg_state !== S_IDLE || bus.memReqValid !== 1'b0)
      $display("FAIL refill_done: state=%0d memReqValid=%b, expected %0d 0",
               dbg_state, bus.memReqValid, S_IDLE);
    else n_pass++;
    m_valid[idx] = 1'b1;
    m_tag[idx]   = TAG_W'(line >> (2 + OFF_W + IDX_W));
    for (int k = 0; k < LINE_INSNS; k++) m_line[idx][k] = base + INSN_WIDTH'(k);
  endtask

  task automatic test_reset();
    rst = 1'b0;
    step();
    step();
    mon_active = 1'b1;
    n_checks++;
    if (bus.icReadHit !== '0 || bus.icReadDataOut !== '0)
      $display("FAIL reset_read: hit=%b data=%h, expected 0 0", bus.icReadHit, bus.icReadDataOut);
    else n_pass++;
    n_checks++;
    if (bus.memReqValid !== 1'b0 || bus.memReqAddr !== '0)
      $display("FAIL reset_req: valid=%b addr=%h, expected 0 0", bus.memReqValid, bus.memReqAddr);
    else n_pass++;
    n_checks++;
    if (dbg_state !== S_IDLE)
      $display("FAIL reset_state: state=%0d, expected %0d", dbg_state, S_IDLE);
    else n_pass++;
`ifdef RSD_ICACHE_FLUSH_EN
    n_checks++;
    if (bus.flushDone !== 1'b0)
      $display("FAIL reset_flushdone: got %b, expected 0", bus.flushDone);
    else n_pass++;
`endif
    rst = 1'b1;
    step();
  endtask

  task automatic test_cold_fill();
    start_miss(32'h100);
    refill(32'h100, 32'hA0, 0, 0);
    issue(32'h100, 1'b0);
    step();
  endtask

  task automatic test_line_end();
    issue(32'h10C, 1'b0);
    issue(32'h108, 1'b0);
    step();
    step();
    n_checks++;
    if (bus.memReqValid !== 1'b0 || dbg_state !== S_IDLE)
      $display("FAIL line_end_norefill: valid=%b state=%0d, expected 0 %0d",
               bus.memReqValid, dbg_state, S_IDLE);
    else n_pass++;
  endtask

  task automatic test_ready_stall();
    start_miss(32'h200);
    refill(32'h200, 32'hB0, 5, 0);
    issue(32'h204, 1'b0);
    step();
  endtask

  task automatic test_conflict();
    start_miss(32'h500);
    refill(32'h500, 32'hC0, 0, 2);
    issue(32'h500, 1'b0);
    step();
    start_miss(32'h100);
    refill(32'h100, 32'hA0, 0, 1);
    issue(32'h104, 1'b0);
    step();
  endtask

  task automatic test_back_to_back();
    logic [ADDR_WIDTH-1:0] a;
    for (int n = 0; n < 16; n++) begin
      a = ($urandom_range(0, 1) == 0) ? 32'h100 : 32'h200;
      a = a + ADDR_WIDTH'(4 * $urandom_range(0, LINE_INSNS - 1));
      issue(a, 1'b0);
    end
    step();
    n_checks++;
    if (bus.memReqValid !== 1'b0)
      $display("FAIL b2b_norefill: memReqValid=%b, expected 0", bus.memReqValid);
    else n_pass++;
  endtask

  task automatic test_reset_mid_refill();
    start_miss(32'h300);
    bus.memReqReady = 1'b1;
    step();
    bus.memReqReady = 1'b0;
    for (int k = 0; k < 2; k++) begin
      bus.memRspValid = 1'b1;
      bus.memRspData  = 32'hD0 + INSN_WIDTH'(k);
      step();
    end
    bus.memRspData = 32'hD2;
    rst = 1'b0;
    step();
    rst = 1'b1;
    model_clear();
    n_checks++;
    if (dbg_state !== S_IDLE || bus.memReqValid !== 1'b0 || bus.memReqAddr !== '0)
      $display("FAIL midrst_state: state=%0d valid=%b addr=%h, expected %0d 0 0",
               dbg_state, bus.memReqValid, bus.memReqAddr, S_IDLE);
    else n_pass++;
    bus.memRspData = 32'hD3;
    step();
    bus.memRspData = 32'hD4;
    step();
    bus.memRspValid = 1'b0;
    n_checks++;
    if (dbg_state !== S_IDLE || bus.memReqValid !== 1'b0)
      $display("FAIL stray_beats: state=%0d valid=%b, expected %0d 0",
               dbg_state, bus.memReqValid, S_IDLE);
    else n_pass++;
    start_miss(32'h100);
    refill(32'h100, 32'hA0, 0, 0);
    issue(32'h100, 1'b0);
    step();
  endtask

`ifdef RSD_ICACHE_FLUSH_EN
  task automatic test_flush();
    int done_at;
    done_at = 0;
    bus.flushReq = 1'b1;
    step();
    bus.flushReq = 1'b0;
    n_checks++;
    if (dbg_state !== S_FLUSH)
      $display("FAIL flush_enter: state=%0d, expected %0d", dbg_state, S_FLUSH);
    else n_pass++;
    for (int c = 1; c <= 200; c++) begin
      if (bus.flushDone === 1'b1) begin
        done_at = c;
        break;
      end
      step();
    end
    n_checks++;
    if (done_at != SETS)
      $display("FAIL flush_done_cycle: got %0d, expected %0d (0 = timeout)", done_at, SETS);
    else n_pass++;
    step();
    model_clear();
    n_checks++;
    if (dbg_state !== S_IDLE || bus.flushDone !== 1'b0)
      $display("FAIL flush_exit: state=%0d done=%b, expected %0d 0", dbg_state, bus.flushDone, S_IDLE);
    else n_pass++;
    start_miss(32'h100);
    refill(32'h100, 32'hA0, 0, 0);
    issue(32'h100, 1'b0);
    step();
  endtask
`endif

  initial begin
    rst              = 1'b0;
    bus.icRE         = 1'b0;
    bus.icReadAddrIn = '0;
    bus.memReqReady  = 1'b0;
    bus.memRspValid  = 1'b0;
    bus.memRspData   = '0;
`ifdef RSD_ICACHE_FLUSH_EN
    bus.flushReq     = 1'b0;
`endif
    model_clear();

    test_reset();
    test_cold_fill();
    test_line_end();
    test_ready_stall();
    test_conflict();
    test_back_to_back();
    test_reset_mid_refill();
`ifdef RSD_ICACHE_FLUSH_EN
    test_flush();
`endif

    step();
    step();
    n_checks++;
    if (exp_q.size() != 0)
      $display("FAIL drain: %0d responses outstanding, expected 0", exp_q.size());
    else n_pass++;
    mon_active = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
